// File: rtl/env_pkg.sv
// Shared types and constants for the moving-average envelope scheduler.
package env_pkg;
  typedef enum logic [1:0] {IDLE, CALC, HOLD} env_state_t;

  localparam int TAPS      = 8;
  localparam int TAPS_LOG2 = 3;

  function automatic int acc_width(input int sample_width);
    return sample_width + TAPS_LOG2;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr, first request wins.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W-1:0] c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = '0;
    for (int i = 1; i <= N; i++) begin
      c = W'((int'(ptr) + i) % N);
      if (en && !any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end
endmodule

// File: rtl/env_avg_scheduler.sv
// One shared 8-tap moving-average engine, round-robin across NUM_CH requesters,
// per-channel history/sum kept locally; result held under valid/ready.
module env_avg_scheduler
  import env_pkg::*;
#(
  parameter  int SAMPLE_WIDTH = 24,
  parameter  int NUM_CH       = 4,
  localparam int CH_W         = $clog2(NUM_CH)
) (
  input  logic                           sample_clock,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              req_valid,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] req_sample,
  output logic [NUM_CH-1:0]              req_ready,
  input  logic [NUM_CH-1:0]              ch_clear,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CH_W-1:0]                out_ch,
  output logic [SAMPLE_WIDTH-1:0]        out_sample,
  output logic                           busy
);
  localparam int ACC_W = acc_width(SAMPLE_WIDTH);

  env_state_t state, state_nxt;

  logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0]           samples;
  logic [NUM_CH-1:0][TAPS-1:0][SAMPLE_WIDTH-1:0] hist;
  logic [NUM_CH-1:0][ACC_W-1:0]                  sum;
  logic [NUM_CH-1:0][TAPS_LOG2-1:0]              wp;

  logic [CH_W-1:0]         cur_ch, rr_ptr, win;
  logic [SAMPLE_WIDTH-1:0] cur_sample, tap;
  logic [ACC_W-1:0]        sum_n;
  logic                    any_req;

  assign samples = req_sample;
  assign busy    = (state != IDLE);

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (state == IDLE),
    .grant (req_ready),
    .idx   (win),
    .any   (any_req)
  );

  // Oldest tap drops out, new sample enters; sum >= every stored tap so no underflow.
  assign tap   = hist[cur_ch][wp[cur_ch]];
  assign sum_n = sum[cur_ch] - ACC_W'(tap) + ACC_W'(cur_sample);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = CALC;
      CALC:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_ch     <= '0;
      cur_sample <= '0;
      rr_ptr     <= CH_W'(NUM_CH - 1);
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sample <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        cur_ch     <= win;
        cur_sample <= samples[win];
        rr_ptr     <= win;
      end
      if (state == CALC) begin
        out_sample <= sum_n[ACC_W-1:TAPS_LOG2];
        out_ch     <= cur_ch;
        out_valid  <= 1'b1;
      end
      if (state == HOLD && out_ready) out_valid <= 1'b0;
    end
  end

  // Clear takes priority over the CALC update; the result already computed still goes out.
  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) begin
      hist <= '0;
      sum  <= '0;
      wp   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_clear[c]) begin
          hist[c] <= '0;
          sum[c]  <= '0;
          wp[c]   <= '0;
        end else if (state == CALC && cur_ch == CH_W'(c)) begin
          hist[c][wp[c]] <= cur_sample;
          sum[c]         <= sum_n;
          wp[c]          <= wp[c] + TAPS_LOG2'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_env_avg_scheduler.sv
// Directed, table-driven bench for env_avg_scheduler with hand-computed expectations.
module tb_env_avg_scheduler;
  localparam int SW = 24;
  localparam int NC = 4;

  logic              sample_clock = 1'b0;
  logic              rst;
  logic [NC-1:0]     req_valid;
  logic [NC*SW-1:0]  req_sample;
  logic [NC-1:0]     req_ready;
  logic [NC-1:0]     ch_clear;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_ch;
  logic [SW-1:0]     out_sample;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          ch;
    logic [23:0] smp;
    bit          clr;
    logic [23:0] exp;
  } vec_t;

  env_avg_scheduler #(.SAMPLE_WIDTH(SW), .NUM_CH(NC)) dut (
    .sample_clock (sample_clock),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_sample   (req_sample),
    .req_ready    (req_ready),
    .ch_clear     (ch_clear),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ch       (out_ch),
    .out_sample   (out_sample),
    .busy         (busy)
  );

  always #5 sample_clock = ~sample_clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sample_clock);
    rst = 1'b1; req_valid = '0; req_sample = '0; ch_clear = '0; out_ready = 1'b1;
    repeat (2) @(negedge sample_clock);
    rst = 1'b0;
  endtask

  // Request one sample on ch, check grant, 2-cycle latency and the tagged result.
  task automatic send(input int ch, input logic [23:0] s, input logic [23:0] exp, input string nm);
    int t;
    int lat;
    @(negedge sample_clock);
    out_ready = 1'b1;
    req_sample[ch*SW +: SW] = s;
    req_valid[ch] = 1'b1;
    #1;
    t = 0;
    while (!req_ready[ch] && t < 50) begin
      @(negedge sample_clock); #1; t++;
    end
    chk({nm, " grant"}, {31'd0, req_ready[ch]}, 32'd1);
    @(negedge sample_clock);
    req_valid[ch] = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge sample_clock); lat++;
    end
    chk({nm, " latency"}, lat, 2);
    chk({nm, " ch"}, {30'd0, out_ch}, ch);
    chk({nm, " sample"}, {8'd0, out_sample}, {8'd0, exp});
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   m[9];
    int   gch[$];
    int   gcy[$];
    int   cyc;
    int   t;
    logic [23:0] hold_s;

    m = '{0, 2097151, 4194303, 6291455, 8388607, 10485759, 12582911, 14680063, 16777215};
    for (int k = 1; k <= 8; k++) begin v = '{0, 24'd800, 1'b0, 24'(100*k)}; tbl.push_back(v); end
    v = '{0, 24'd800, 1'b0, 24'd800}; tbl.push_back(v);
    for (int k = 1; k <= 8; k++) begin v = '{1, 24'd800, 1'b0, 24'(100*k)}; tbl.push_back(v); end
    v = '{1, 24'd800, 1'b1, 24'd100}; tbl.push_back(v);
    v = '{0, 24'd800, 1'b0, 24'd800}; tbl.push_back(v);
    for (int k = 1; k <= 8; k++) begin v = '{2, 24'hFFFFFF, 1'b0, 24'(m[k])}; tbl.push_back(v); end
    for (int k = 7; k >= 0; k--) begin v = '{2, 24'd0, 1'b0, 24'(m[k])}; tbl.push_back(v); end

    rst = 1'b1; req_valid = '0; req_sample = '0; ch_clear = '0; out_ready = 1'b0;
    do_reset();
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset req_ready", {28'd0, req_ready}, 0);
    chk("reset out_ch/sample", {6'd0, out_ch, out_sample}, 0);

    // Reset while a result is held.
    @(negedge sample_clock);
    out_ready = 1'b0;
    req_sample[0 +: SW] = 24'd800;
    req_valid[0] = 1'b1;
    @(negedge sample_clock);
    req_valid[0] = 1'b0;
    repeat (3) @(negedge sample_clock);
    chk("pre-reset holding", {31'd0, out_valid}, 1);
    #1 rst = 1'b1;
    #1;
    chk("midhold rst out_valid", {31'd0, out_valid}, 0);
    chk("midhold rst busy", {31'd0, busy}, 0);
    @(negedge sample_clock);
    rst = 1'b0;
    send(0, 24'd80, 24'd10, "post-reset ch0");

    // Contention: all channels request continuously.
    do_reset();
    @(negedge sample_clock);
    req_sample = {24'd4, 24'd3, 24'd2, 24'd1};
    req_valid = '1;
    out_ready = 1'b1;
    cyc = 0;
    while (gch.size() < 8 && cyc < 60) begin
      #1;
      if (req_ready != '0) begin
        chk("contention onehot", {31'd0, $onehot(req_ready)}, 1);
        for (int i = 0; i < NC; i++) if (req_ready[i]) gch.push_back(i);
        gcy.push_back(cyc);
      end
      @(negedge sample_clock);
      cyc++;
    end
    req_valid = '0;
    chk("contention grant count", gch.size(), 8);
    for (int k = 0; k < gch.size(); k++) begin
      chk("contention order", gch[k], k % NC);
      if (k > 0) chk("contention spacing", gcy[k] - gcy[k-1], 3);
    end
    repeat (4) @(negedge sample_clock);

    // Table: step response, wrap, clear, full-scale, decay.
    do_reset();
    foreach (tbl[i]) begin
      if (tbl[i].clr) begin
        @(negedge sample_clock); ch_clear[tbl[i].ch] = 1'b1;
        @(negedge sample_clock); ch_clear = '0;
      end
      send(tbl[i].ch, tbl[i].smp, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Clear landing in the CALC cycle: result keeps the pre-clear value, state ends cleared.
    @(negedge sample_clock);
    req_sample[2*SW +: SW] = 24'd800;
    req_valid[2] = 1'b1;
    out_ready = 1'b1;
    #1;
    t = 0;
    while (!req_ready[2] && t < 50) begin @(negedge sample_clock); #1; t++; end
    chk("calc-clear grant", {31'd0, req_ready[2]}, 1);
    @(negedge sample_clock);
    req_valid[2] = 1'b0;
    ch_clear[2] = 1'b1;
    @(negedge sample_clock);
    ch_clear = '0;
    chk("calc-clear valid", {31'd0, out_valid}, 1);
    chk("calc-clear sample", {8'd0, out_sample}, 100);
    send(2, 24'd800, 24'd100, "after calc-clear");

    // Backpressure: result frozen, no grants while held.
    @(negedge sample_clock);
    out_ready = 1'b0;
    req_sample[3*SW +: SW] = 24'd8000;
    req_valid[3] = 1'b1;
    @(negedge sample_clock);
    req_valid[3] = 1'b0;
    t = 0;
    while (!out_valid && t < 10) begin @(negedge sample_clock); t++; end
    chk("bp valid", {31'd0, out_valid}, 1);
    hold_s = out_sample;
    chk("bp sample", {8'd0, hold_s}, 1000);
    req_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge sample_clock);
      chk("bp stable", {out_valid, req_ready, out_ch, out_sample}, {1'b1, 4'b0, 2'd3, 24'd1000});
    end
    req_valid[0] = 1'b0;
    out_ready = 1'b1;
    @(negedge sample_clock);
    chk("bp released", {31'd0, out_valid}, 0);
    repeat (2) @(negedge sample_clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
